// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the 8-bit single-cycle CPU datapath.
//   DATA_W     : register / data-port width
//   ADDR_W     : register index width
//   NREGS      : number of general-purpose registers (2**ADDR_W)
//   word_t     : one datapath word
//   reg_addr_t : one register index
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  typedef logic [7:0] word_t;
  typedef logic [2:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/reg_read_port.sv
// ---------------------------------------------------------------------------
// reg_read_port
// One asynchronous read port of the register file: selects the addressed
// register from the flattened register array. With REG_FILE_BYPASS_EN
// defined, a write that will commit on the coming edge to the same index is
// forwarded straight to the output in the current cycle.
//
// Ports:
//   regs     in   NREGS x DATA_W  current register contents
//   rd_addr  in   ADDR_W          register index to read
//   wr_fire  in   1               (bypass build only) write commits this edge
//   wr_addr  in   ADDR_W          (bypass build only) write destination
//   wr_data  in   DATA_W          (bypass build only) write data
//   rd_data  out  DATA_W          selected register value
//
// Optional feature macro: REG_FILE_BYPASS_EN
// ---------------------------------------------------------------------------
module reg_read_port #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            rd_addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic                         wr_fire,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
`endif
  output logic [DATA_W-1:0]            rd_data
);

  import cpu_pkg::*;

  always_comb begin
    rd_data = regs[rd_addr];
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so the reader sees it before the edge.
    if (wr_fire && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
  end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 8 x 8-bit general-purpose register file: two asynchronous read ports and
// one synchronous write port. Writes are held off while data memory stalls
// (BUSYWAIT) and are discarded on a reset edge. OUT1 drives ALU DATA1;
// OUT2 drives the operand-select mux (directly and through negation).
//
// Ports:
//   CLK          in   1       system clock, rising-edge active
//   RESET        in   1       synchronous active-high, clears all registers
//   IN           in   DATA_W  write data
//   INADDRESS    in   ADDR_W  write destination index
//   WRITE        in   1       write enable
//   BUSYWAIT     in   1       memory stall, suppresses writes
//   OUT1ADDRESS  in   ADDR_W  read port 1 index
//   OUT2ADDRESS  in   ADDR_W  read port 2 index
//   OUT1         out  DATA_W  read port 1 data
//   OUT2         out  DATA_W  read port 2 data
//
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write forwarding
// onto both read ports). Undefined: reads return the stored value only.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2
);

  import cpu_pkg::*;

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;
  logic                         write_fire;

  // A write commits only when enabled, not stalled and not being reset.
  // An unknown WRITE or INADDRESS falls through to "hold", so X cannot
  // smear into the array in simulation.
  always_comb begin
    write_fire = WRITE && !BUSYWAIT && !RESET;
    regs_d     = regs_q;
    if (write_fire && !$isunknown(INADDRESS)) begin
      regs_d[INADDRESS] = IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flag a control unit that drives an unknown write enable, or an unknown
  // destination while writing.
  wr_ctrl_known_a : assert property (@(posedge CLK) disable iff (RESET)
    !$isunknown(WRITE) && ((WRITE !== 1'b1) || !$isunknown(INADDRESS)));

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_read_port1 (
    .regs    (regs_q),
    .rd_addr (OUT1ADDRESS),
`ifdef REG_FILE_BYPASS_EN
    .wr_fire (write_fire),
    .wr_addr (INADDRESS),
    .wr_data (IN),
`endif
    .rd_data (OUT1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_read_port2 (
    .regs    (regs_q),
    .rd_addr (OUT2ADDRESS),
`ifdef REG_FILE_BYPASS_EN
    .wr_fire (write_fire),
    .wr_addr (INADDRESS),
    .wr_data (IN),
`endif
    .rd_data (OUT2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, all checked against an array model of the eight registers.
// Honours REG_FILE_BYPASS_EN for the expected same-cycle read value.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       BUSYWAIT;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;

  // Downstream operand-select mux inputs fed by OUT2.
  logic [7:0] mux_in1;
  logic [7:0] mux_in2;
  assign mux_in1 = OUT2;
  assign mux_in2 = 8'(-OUT2);

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] model [8];
  bit         model_valid = 0;

  reg_file dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .BUSYWAIT    (BUSYWAIT),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .OUT1        (OUT1),
    .OUT2        (OUT2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // What a read port should show right now, given model and live inputs.
  function automatic logic [7:0] expRead(input logic [2:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && !BUSYWAIT && !RESET && (a == INADDRESS)) return IN;
`endif
    return model[a];
  endfunction

  task automatic checkPorts(input string tag);
    logic [7:0] e2;
    if (model_valid) begin
      e2 = expRead(OUT2ADDRESS);
      checkOutput({tag, "_out1"}, OUT1, expRead(OUT1ADDRESS));
      checkOutput({tag, "_out2"}, OUT2, e2);
      checkOutput({tag, "_mux_in1"}, mux_in1, e2);
      checkOutput({tag, "_mux_in2"}, mux_in2, 8'(-e2));
    end
  endtask

  task automatic driveInputs(input logic rst, input logic wr, input logic [2:0] wa,
                             input logic [7:0] din, input logic busy,
                             input logic [2:0] a1, input logic [2:0] a2);
    @(negedge CLK);
    RESET       = rst;
    WRITE       = wr;
    INADDRESS   = wa;
    IN          = din;
    BUSYWAIT    = busy;
    OUT1ADDRESS = a1;
    OUT2ADDRESS = a2;
    #1;
  endtask

  // Rising edge: update the model from the register-file rules, then settle.
  task automatic clockEdge;
    @(posedge CLK);
    if (RESET) begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      model_valid = 1;
    end else if (WRITE && !BUSYWAIT) begin
      model[INADDRESS] = IN;
    end
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic wr,
                               input logic [2:0] wa, input logic [7:0] din,
                               input logic busy, input logic [2:0] a1, input logic [2:0] a2);
    driveInputs(rst, wr, wa, din, busy, a1, a2);
    checkPorts({tag, "_pre"});
    clockEdge();
    checkPorts({tag, "_post"});
  endtask

  logic [7:0] v;

  initial begin
    RESET = 0; WRITE = 0; INADDRESS = 0; IN = 0; BUSYWAIT = 0;
    OUT1ADDRESS = 0; OUT2ADDRESS = 0;

    // Initial reset, then reset clear of a preloaded r3.
    applyStimulus("init_rst", 1, 0, 0, 8'h00, 0, 0, 0);
    applyStimulus("preload", 0, 1, 3, 8'h5A, 0, 3, 3);
    checkOutput("preload_r3", OUT1, 8'h5A);
    applyStimulus("rst_clear", 1, 0, 0, 8'h00, 0, 3, 3);
    checkOutput("rst_clear_r3", OUT1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("rst_all", 0, 0, 0, 8'h00, 0, 3'(i), 3'(7 - i));
      checkOutput("rst_all_r", OUT1, 8'h00);
    end

    // Basic write/read on both ports.
    applyStimulus("basic", 0, 1, 2, 8'hA7, 0, 2, 2);
    driveInputs(0, 0, 0, 8'h00, 0, 2, 2);
    checkOutput("basic_out1", OUT1, 8'hA7);
    checkOutput("basic_out2", OUT2, 8'hA7);
    checkPorts("basic_hold");

    // Reset dominates a coincident write.
    applyStimulus("rst_prio_pre", 0, 1, 5, 8'h77, 0, 5, 2);
    applyStimulus("rst_prio", 1, 1, 5, 8'hFF, 0, 5, 2);
    driveInputs(0, 0, 0, 8'h00, 0, 5, 2);
    checkOutput("rst_prio_r5", OUT1, 8'h00);
    checkOutput("rst_prio_r2", OUT2, 8'h00);

    // Stall: three edges held off, then commit on the first free edge.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 0, 1, 4, 8'h3C, 1, 4, 4);
      checkOutput("stall_r4", OUT1, 8'h00);
    end
    applyStimulus("stall_release", 0, 1, 4, 8'h3C, 0, 4, 4);
    checkOutput("stall_commit_r4", OUT1, 8'h3C);

    // Same-index read during write.
    applyStimulus("same_setup", 0, 1, 1, 8'h10, 0, 1, 1);
    driveInputs(0, 1, 1, 8'h20, 0, 0, 1);
`ifdef REG_FILE_BYPASS_EN
    checkOutput("same_before_edge", OUT2, 8'h20);
`else
    checkOutput("same_before_edge", OUT2, 8'h10);
`endif
    checkPorts("same_pre");
    clockEdge();
    checkOutput("same_after_edge", OUT2, 8'h20);
    checkPorts("same_post");

    // Sweep: r0..r7 = 01,02,..,80 then read pairs (i, 7-i).
    for (int i = 0; i < 8; i++) begin
      v = 8'h01 << i;
      applyStimulus("sweep_wr", 0, 1, 3'(i), v, 0, 3'(i), 3'(i));
    end
    for (int i = 0; i < 8; i++) begin
      driveInputs(0, 0, 0, 8'h00, 0, 3'(i), 3'(7 - i));
      v = 8'h01 << i;
      checkOutput("sweep_out1", OUT1, v);
      v = 8'h01 << (7 - i);
      checkOutput("sweep_out2", OUT2, v);
      checkOutput("sweep_mux_in1", mux_in1, v);
      checkPorts("sweep_rd");
    end

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 9) < 6),
                    3'($urandom),
                    8'($urandom),
                    ($urandom_range(0, 9) < 3),
                    3'($urandom),
                    3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file
